// File: rtl/led_pkg.sv
// Shared definitions for the LED pulse stretcher.
//   LED_IDLE / LED_ON / LED_GAP : FSM state encodings
//   DEF_ON_CNT / DEF_OFF_CNT    : default blink timing at 12 MHz
//   max_int()                   : elaboration-time helper for sizing counters
package led_pkg;

  localparam logic [1:0] LED_IDLE = 2'd0;
  localparam logic [1:0] LED_ON   = 2'd1;
  localparam logic [1:0] LED_GAP  = 2'd2;

  // 200 ms on, 20 ms forced gap at 12 MHz
  localparam int DEF_ON_CNT  = 2400000;
  localparam int DEF_OFF_CNT = 240000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_sat_counter.sv
// Saturating up/down counter with a sticky "dropped at saturation" flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : count up / count down; both together hold the value
//   clr_flag   : synchronous clear of the sticky flag (a new drop wins)
//   count      : current value, saturates at 2^W-1 and floors at 0
//   sat_flag   : sticky, set when an increment is lost at saturation
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr_flag,
  output logic [W-1:0] count,
  output logic         sat_flag
);
  import led_pkg::*;

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic up_only;
  logic dn_only;
  logic drop;

  assign up_only = inc & ~dec;
  assign dn_only = dec & ~inc;
  assign drop    = up_only & (count == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (up_only && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end else if (dn_only && (count != '0)) begin
        count <= count - 1'b1;
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (drop) begin
        sat_flag <= 1'b1;
      end else if (clr_flag) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle events into visible LED blinks with a guaranteed
// on-time and a guaranteed off-gap; events arriving mid-blink are queued.
//   clk       : 12 MHz system clock
//   rst_n     : asynchronous active-low reset
//   event_in  : single-cycle event strobe
//   clear_ovf : synchronous clear of the overflow flag
//   led_out   : registered LED pad drive (LED_ACTIVE_VALUE lights it)
//   busy      : registered, high in ON and GAP
//   pending   : queued events still to be blinked
//   overflow  : sticky, an event was dropped with the queue full
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int   ON_CNT           = DEF_ON_CNT,
  parameter int   OFF_CNT          = DEF_OFF_CNT,
  parameter int   PEND_W           = 4,
  parameter logic LED_ACTIVE_VALUE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_in,
  input  logic              clear_ovf,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CW = $clog2(max_int(ON_CNT, OFF_CNT) + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CNT - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CNT - 1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          gap_end;
  logic          led_d;
  logic          busy_d;
  logic          pend_inc;
  logic          pend_dec;

  assign gap_end = (state_q == LED_GAP) && (cnt_q == OFF_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LED_IDLE;
      cnt_q   <= '0;
      led_out <= ~LED_ACTIVE_VALUE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_out <= led_d;
      busy    <= busy_d;
    end
  end

  // Next-state and timing counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      LED_IDLE: if (event_in) state_d = LED_ON;
      LED_ON:   if (cnt_q == ON_LAST) state_d = LED_GAP;
      LED_GAP: begin
        // Chain straight into the next blink when anything is queued,
        // including an event landing on this very cycle
        if (gap_end) state_d = ((pending != '0) || event_in) ? LED_ON : LED_IDLE;
      end
      default:  state_d = LED_IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != LED_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs: registered from the next state so they track state_q exactly
  always_comb begin
    led_d  = (state_d == LED_ON) ? LED_ACTIVE_VALUE : ~LED_ACTIVE_VALUE;
    busy_d = (state_d != LED_IDLE);
  end

  // Queue accounting. An event in IDLE starts a blink directly and is not
  // queued. On the last gap cycle one queued event is consumed; if an event
  // arrives on that same cycle inc and dec cancel, which is total-1 exactly.
  assign pend_inc = event_in & (state_q != LED_IDLE);
  assign pend_dec = gap_end;

  sat_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pend_inc),
    .dec      (pend_dec),
    .clr_flag (clear_ovf),
    .count    (pending),
    .sat_flag (overflow)
  );

endmodule

// File: tb/tb_led_pulse_stretcher.sv
module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       event_in = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  led_pulse_stretcher #(
    .ON_CNT(5), .OFF_CNT(3), .PEND_W(2), .LED_ACTIVE_VALUE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .event_in(event_in), .clear_ovf(clear_ovf),
    .led_out(led_out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       led;
    logic       bsy;
    logic [1:0] pnd;
    logic       ovf;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
  endtask

  task automatic push(input int base, input int off, input logic l, input logic b,
                      input int p, input logic o);
    rec_t r;
    r.cyc = base + off; r.led = l; r.bsy = b; r.pnd = 2'(p); r.ovf = o;
    q.push_back(r);
  endtask

  // Drive one input cycle so that it is sampled by clock edge number e.
  task automatic drive_at(input int e, input logic ev, input logic clr);
    for (int k = 0; k < 1000 && (cyc + 1 != e); k++) @(negedge clk);
    if (cyc + 1 != e) check("drive_timeout", cyc + 1, e);
    event_in  = ev;
    clear_ovf = clr;
    @(negedge clk);
    event_in  = 1'b0;
    clear_ovf = 1'b0;
  endtask

  task automatic settle(input string name, input int until_edge);
    for (int k = 0; k < 1000 && (cyc < until_edge); k++) @(negedge clk);
    check(name, q.size(), 0);
    q.delete();
  endtask

  // Monitor: every change of the observable outputs must match the next
  // expected record, both in value and in the clock edge it follows.
  initial begin
    logic [4:0] cur, prev;
    rec_t r;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {led_out, busy, pending, overflow};
      if (mon_en && cur != prev) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: cyc %0d led=%b busy=%b pend=%0d ovf=%b",
                   cyc, led_out, busy, pending, overflow);
        end else begin
          r = q.pop_front();
          if (cyc == r.cyc && cur == {r.led, r.bsy, r.pnd, r.ovf}) passed++;
          else $display("FAIL change: got cyc %0d led=%b busy=%b pend=%0d ovf=%b, expected cyc %0d led=%b busy=%b pend=%0d ovf=%b",
                        cyc, led_out, busy, pending, overflow,
                        r.cyc, r.led, r.bsy, r.pnd, r.ovf);
        end
      end
      prev = cur;
    end
  end

  initial begin
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_led", led_out, 1);
    check("rst_busy", busy, 0);
    check("rst_pend", pending, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single event
    t = cyc + 1;
    push(t, 0, 0, 1, 0, 0);
    push(t, 5, 1, 1, 0, 0);
    push(t, 8, 1, 0, 0, 0);
    drive_at(t, 1, 0);
    settle("single_done", t + 12);

    // Three events back to back: three blinks, 3-cycle gaps
    t = cyc + 1;
    push(t, 0, 0, 1, 0, 0);  push(t, 1, 0, 1, 1, 0);  push(t, 2, 0, 1, 2, 0);
    push(t, 5, 1, 1, 2, 0);  push(t, 8, 0, 1, 1, 0);  push(t, 13, 1, 1, 1, 0);
    push(t, 16, 0, 1, 0, 0); push(t, 21, 1, 1, 0, 0); push(t, 24, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_at(t + i, 1, 0);
    settle("three_done", t + 28);

    // Saturation: five events, four blinks, overflow set on the fifth
    t = cyc + 1;
    push(t, 0, 0, 1, 0, 0);  push(t, 1, 0, 1, 1, 0);  push(t, 2, 0, 1, 2, 0);
    push(t, 3, 0, 1, 3, 0);  push(t, 4, 0, 1, 3, 1);  push(t, 5, 1, 1, 3, 1);
    push(t, 8, 0, 1, 2, 1);  push(t, 13, 1, 1, 2, 1); push(t, 16, 0, 1, 1, 1);
    push(t, 21, 1, 1, 1, 1); push(t, 24, 0, 1, 0, 1); push(t, 29, 1, 1, 0, 1);
    push(t, 32, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive_at(t + i, 1, 0);
    settle("sat_done", t + 36);
    check("sat_ovf_sticky", overflow, 1);

    // Lone clear while idle
    t = cyc + 1;
    push(t, 0, 1, 0, 0, 0);
    drive_at(t, 0, 1);
    settle("clear_idle_done", t + 3);

    // Event on the final gap cycle chains directly into the next blink
    t = cyc + 1;
    push(t, 0, 0, 1, 0, 0);  push(t, 5, 1, 1, 0, 0);  push(t, 8, 0, 1, 0, 0);
    push(t, 13, 1, 1, 0, 0); push(t, 16, 1, 0, 0, 0);
    drive_at(t, 1, 0);
    drive_at(t + 8, 1, 0);
    settle("b2b_done", t + 20);

    // Clear together with a dropping event: set wins; later clear mid-blink
    t = cyc + 1;
    push(t, 0, 0, 1, 0, 0);  push(t, 1, 0, 1, 1, 0);  push(t, 2, 0, 1, 2, 0);
    push(t, 3, 0, 1, 3, 0);  push(t, 4, 0, 1, 3, 1);  push(t, 5, 1, 1, 3, 1);
    push(t, 8, 0, 1, 2, 1);  push(t, 10, 0, 1, 2, 0); push(t, 13, 1, 1, 2, 0);
    push(t, 16, 0, 1, 1, 0); push(t, 21, 1, 1, 1, 0); push(t, 24, 0, 1, 0, 0);
    push(t, 29, 1, 1, 0, 0); push(t, 32, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive_at(t + i, 1, (i == 4));
    drive_at(t + 10, 0, 1);
    settle("clr_race_done", t + 36);

    // Reset in the middle of a blink with two events queued
    t = cyc + 1;
    push(t, 0, 0, 1, 0, 0);  push(t, 1, 0, 1, 1, 0);  push(t, 2, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) drive_at(t + i, 1, 0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_led", led_out, 1);
    check("midrst_busy", busy, 0);
    check("midrst_pend", pending, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_queue", q.size(), 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_led", led_out, 1);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: cyc %0d", cyc);
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "timeout");
  end

endmodule
